// File: rtl/theta_slice_packer_if.sv
// Slice word hand-off bus between the theta slice packer and the next
// permutation stage: a packed slice word with its depth index, moved over
// a valid/ready handshake.
interface theta_slice_packer_if #(
  parameter int SLICE_W = 25,
  parameter int IDX_W   = 6
);
  logic [SLICE_W-1:0] slice_out;
  logic [IDX_W-1:0]   slice_idx;
  logic               slice_valid;
  logic               slice_ready;

  modport master (
    output slice_out,
    output slice_idx,
    output slice_valid,
    input  slice_ready
  );

  modport slave (
    input  slice_out,
    input  slice_idx,
    input  slice_valid,
    output slice_ready
  );
endinterface

// File: rtl/theta_slice_packer.sv
// Theta slice packer: collects the serial theta output one bit per enabled
// cycle, packs 25 bits MSB-first into a slice word, queues words in a small
// FIFO and hands them downstream over valid/ready. Counts slices 0..63,
// flags the end of the state (done) and any slice dropped on a full FIFO.
module theta_slice_packer #(
  parameter int SLICE_W    = 25,
  parameter int NUM_SLICES = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init0,
  input  logic                 en,
  input  logic                 pin,
  theta_slice_packer_if.master slice_bus,
  output logic                 done,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(NUM_SLICES);
  localparam int BIT_W = $clog2(SLICE_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(SLICE_W - 1);
  localparam logic [IDX_W-1:0] LAST_SLICE = IDX_W'(NUM_SLICES - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   slice_cnt;
  logic [SLICE_W-1:0] pack_reg;

  logic [SLICE_W-1:0] word_mem [FIFO_DEPTH];
  logic [IDX_W-1:0]   idx_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               accepting;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [SLICE_W-1:0] full_word;

  // Decode this cycle's bit acceptance, slice completion and FIFO moves;
  // the word includes the current bit so a completing slice pushes intact.
  always_comb begin
    accepting  = (state == COLLECT) && en && !init0;
    push_req   = accepting && (bit_cnt == LAST_BIT);
    fifo_full  = (count == DEPTH_CNT);
    fifo_empty = (count == '0);
    pop        = !fifo_empty && slice_bus.slice_ready;
    push_ok    = push_req && (!fifo_full || pop);
    full_word  = {pack_reg[SLICE_W-2:0], pin};
  end

  // Head of the FIFO is driven straight from registers, zeroed when empty.
  assign slice_bus.slice_valid = !fifo_empty;
  assign slice_bus.slice_out   = fifo_empty ? '0 : word_mem[rd_ptr];
  assign slice_bus.slice_idx   = fifo_empty ? '0 : idx_mem[rd_ptr];

  // Shift accepted bits in MSB-first and track bit/slice position; the
  // slice index advances even when its word is dropped so depth stays aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      slice_cnt <= '0;
      pack_reg  <= '0;
    end else if (init0) begin
      bit_cnt   <= '0;
      slice_cnt <= '0;
      pack_reg  <= '0;
    end else if (accepting) begin
      pack_reg <= full_word;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt   <= '0;
        slice_cnt <= slice_cnt + IDX_W'(1);
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Slice word FIFO: registered write, no fall-through, simultaneous push
  // and pop allowed when full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_mem[i] <= '0;
        idx_mem[i]  <= '0;
      end
    end else if (init0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        word_mem[wr_ptr] <= full_word;
        idx_mem[wr_ptr]  <= slice_cnt;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // Phase control plus sticky done/overflow; done rises on the edge that
  // pops the final word so it is visible the cycle after the last hand-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (init0) begin
      state    <= COLLECT;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (push_req && (slice_cnt == LAST_SLICE)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty || ((count == CNT_W'(1)) && pop)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule
